// File: rtl/adc_pkg.sv
// Shared widths, FSM state type and mask helpers for the ADC scan averager.
package adc_pkg;

    localparam int unsigned ADC_W = 10;
    localparam int unsigned CH_W  = 4;
    localparam int unsigned N_CH  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StAccum,
        StEmit
    } state_e;

    // An empty scan mask would leave nothing to scan, so it falls back to channel 0.
    function automatic logic [N_CH-1:0] eff_mask(input logic [N_CH-1:0] mask);
        return (mask == '0) ? N_CH'(1) : mask;
    endfunction

    function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] mask);
        logic [CH_W-1:0] ch;
        ch = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) ch = CH_W'(i);
        end
        return ch;
    endfunction

endpackage

// File: rtl/adc_scan_averager_if.sv
// Sample/channel handshake with the AVR interface plus the averaged result bus.
interface adc_scan_averager_if;
    import adc_pkg::*;

    logic             new_sample;
    logic [ADC_W-1:0] sample;
    logic [CH_W-1:0]  sample_channel;
    logic [CH_W-1:0]  channel;
    logic             avg_valid;
    logic [ADC_W-1:0] avg;
    logic [CH_W-1:0]  avg_channel;

    modport slave (
        input  new_sample, sample, sample_channel,
        output channel, avg_valid, avg, avg_channel
    );

    modport master (
        output new_sample, sample, sample_channel,
        input  channel, avg_valid, avg, avg_channel
    );

endinterface

// File: rtl/adc_next_channel.sv
// Combinational search for the next set mask bit above cur, wrapping to the lowest set bit.
module adc_next_channel
    import adc_pkg::*;
(
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] cur,
    output logic [CH_W-1:0] next
);

    // Descending scan so the closest set bit above cur is the last one written.
    always_comb begin
        next = lowest_ch(mask);
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (CH_W'(i) > cur)) next = CH_W'(i);
        end
    end

endmodule

// File: rtl/adc_scan_averager.sv
// Scans the masked ADC channels, averages 2^AVG_LOG2 samples per channel and emits the
// rounded mean with its channel number.
module adc_scan_averager
    import adc_pkg::*;
#(
    parameter int unsigned    AVG_LOG2 = 4,
    parameter logic [15:0]    CH_MASK  = 16'h03F3,
    parameter int unsigned    DISCARD  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    adc_scan_averager_if.slave  adc
);

    localparam logic [N_CH-1:0] MASK     = eff_mask(CH_MASK);
    localparam logic [CH_W-1:0] FIRST_CH = lowest_ch(MASK);
    localparam int unsigned     AW       = ADC_W + AVG_LOG2;
    localparam int unsigned     CW       = AVG_LOG2 + 1;
    localparam logic [CW-1:0]   N_SAMP   = CW'(1) << AVG_LOG2;
    localparam int unsigned     RND_SH   = (AVG_LOG2 == 0) ? 0 : AVG_LOG2 - 1;
    localparam logic [AW-1:0]   RND      = (AVG_LOG2 == 0) ? '0 : (AW'(1) << RND_SH);
    localparam state_e          ST_START = (DISCARD != 0) ? StSettle : StAccum;

    state_e           state_q, state_d;
    logic [CH_W-1:0]  channel_q, channel_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             avg_valid_q, avg_valid_d;
    logic [ADC_W-1:0] avg_q, avg_d;
    logic [CH_W-1:0]  avg_ch_q, avg_ch_d;
    logic [CH_W-1:0]  next_ch;
    logic             match;
    logic [AW-1:0]    rounded;

    adc_next_channel u_next_channel (
        .mask (MASK),
        .cur  (channel_q),
        .next (next_ch)
    );

    assign match   = adc.new_sample && (adc.sample_channel == channel_q);
    // Cannot carry out: the largest sum plus half an LSB stays below 1024 * 2^AVG_LOG2.
    assign rounded = acc_q + RND;

    always_comb begin
        state_d     = state_q;
        channel_d   = channel_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_valid_d = 1'b0;
        avg_d       = avg_q;
        avg_ch_d    = avg_ch_q;

        if (!enable) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = ST_START;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
                StSettle: begin
                    if (match) begin
                        state_d = StAccum;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                StAccum: begin
                    if (match) begin
                        acc_d = acc_q + AW'(adc.sample);
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d == N_SAMP) state_d = StEmit;
                    end
                end
                StEmit: begin
                    avg_valid_d = 1'b1;
                    avg_d       = ADC_W'(rounded >> AVG_LOG2);
                    avg_ch_d    = channel_q;
                    channel_d   = next_ch;
                    state_d     = ST_START;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
                default: state_d = StIdle;
            endcase
        end

        // Whenever the scan stops, it restarts from the first channel.
        if (state_d == StIdle) channel_d = FIRST_CH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            channel_q   <= FIRST_CH;
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_valid_q <= 1'b0;
            avg_q       <= '0;
            avg_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            channel_q   <= channel_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_valid_q <= avg_valid_d;
            avg_q       <= avg_d;
            avg_ch_q    <= avg_ch_d;
        end
    end

    assign adc.channel     = channel_q;
    assign adc.avg_valid   = avg_valid_q;
    assign adc.avg         = avg_q;
    assign adc.avg_channel = avg_ch_q;

endmodule

// File: tb/tb_adc_scan_averager.sv
// Directed and randomized checks of two averager configurations against a sum/count model.
module tb_adc_scan_averager;
    import adc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic en0, en1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;

    always #10 clk = ~clk;

    adc_scan_averager_if ifc0 ();
    adc_scan_averager_if ifc1 ();

    adc_scan_averager #(.AVG_LOG2(4), .CH_MASK(16'h03F3), .DISCARD(1)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (en0),
        .adc    (ifc0)
    );

    adc_scan_averager #(.AVG_LOG2(2), .CH_MASK(16'h0000), .DISCARD(0)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (en1),
        .adc    (ifc1)
    );

    // ---------------- reference model ----------------
    function automatic int p_log2(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic bit p_disc(input int k);
        return k == 0;
    endfunction

    function automatic logic [15:0] p_mask(input int k);
        logic [15:0] m;
        m = (k == 0) ? 16'h03F3 : 16'h0000;
        return (m == 16'h0000) ? 16'h0001 : m;
    endfunction

    function automatic int m_lowest(input int k);
        logic [15:0] m;
        m = p_mask(k);
        for (int c = 0; c < 16; c++) if (m[c]) return c;
        return 0;
    endfunction

    function automatic int m_next(input int k, input int ch);
        logic [15:0] m;
        m = p_mask(k);
        for (int i = 1; i <= 16; i++) if (m[(ch + i) % 16]) return (ch + i) % 16;
        return ch;
    endfunction

    bit m_run [2];
    bit m_drop [2];
    bit m_emit [2];
    bit m_valid [2];
    int m_sum [2];
    int m_cnt [2];
    int m_ch [2];
    int m_avg [2];
    int m_avgch [2];

    task automatic model_step(input int k, input logic rs, input logic e, input logic ns,
                              input int smp, input int sch);
        int n;
        n = 1 << p_log2(k);
        m_valid[k] = 1'b0;
        if (!rs) begin
            m_run[k] = 0; m_emit[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
            m_ch[k] = m_lowest(k); m_avg[k] = 0; m_avgch[k] = 0;
        end else if (!e) begin
            m_run[k] = 0; m_emit[k] = 0; m_sum[k] = 0; m_cnt[k] = 0;
            m_ch[k] = m_lowest(k);
        end else if (!m_run[k]) begin
            m_run[k] = 1; m_drop[k] = p_disc(k); m_sum[k] = 0; m_cnt[k] = 0;
        end else if (m_emit[k]) begin
            m_valid[k] = 1'b1;
            m_avg[k]   = (m_sum[k] + n / 2) / n;
            m_avgch[k] = m_ch[k];
            m_ch[k]    = m_next(k, m_ch[k]);
            m_emit[k]  = 0; m_sum[k] = 0; m_cnt[k] = 0; m_drop[k] = p_disc(k);
        end else if (ns === 1'b1 && sch == m_ch[k]) begin
            if (m_drop[k]) begin
                m_drop[k] = 0;
            end else begin
                m_sum[k] += smp;
                m_cnt[k]++;
                if (m_cnt[k] == n) m_emit[k] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_n, en0, ifc0.new_sample, int'(ifc0.sample), int'(ifc0.sample_channel));
        model_step(1, rst_n, en1, ifc1.new_sample, int'(ifc1.sample), int'(ifc1.sample_channel));
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dut0 avg_valid", int'(ifc0.avg_valid), int'(m_valid[0]));
            chk("dut0 avg", int'(ifc0.avg), m_avg[0]);
            chk("dut0 avg_channel", int'(ifc0.avg_channel), m_avgch[0]);
            chk("dut0 channel", int'(ifc0.channel), m_ch[0]);
            chk("dut1 avg_valid", int'(ifc1.avg_valid), int'(m_valid[1]));
            chk("dut1 avg", int'(ifc1.avg), m_avg[1]);
            chk("dut1 avg_channel", int'(ifc1.avg_channel), m_avgch[1]);
            chk("dut1 channel", int'(ifc1.channel), m_ch[1]);
        end
    end

    typedef struct {int avg; int ch; int nxt;} res_t;
    res_t rq0[$];
    res_t rq1[$];

    always @(negedge clk) begin
        if (ifc0.avg_valid === 1'b1)
            rq0.push_back('{int'(ifc0.avg), int'(ifc0.avg_channel), int'(ifc0.channel)});
        if (ifc1.avg_valid === 1'b1)
            rq1.push_back('{int'(ifc1.avg), int'(ifc1.avg_channel), int'(ifc1.channel)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int k, input logic ns, input int smp, input int sch);
        if (k == 0) begin
            ifc0.new_sample = ns; ifc0.sample = 10'(smp); ifc0.sample_channel = 4'(sch);
        end else begin
            ifc1.new_sample = ns; ifc1.sample = 10'(smp); ifc1.sample_channel = 4'(sch);
        end
    endtask

    task automatic feed(input int k, input int ch, input int val);
        set_in(k, 1'b1, val, ch);
        tick();
        set_in(k, 1'b0, 0, 0);
    endtask

    function automatic int rq_size(input int k);
        return (k == 0) ? rq0.size() : rq1.size();
    endfunction

    task automatic wait_result(input int k, input int e_avg, input int e_ch, input int e_nxt,
                               input string name);
        res_t r;
        for (int i = 0; i < 8 && rq_size(k) == 0; i++) tick();
        if (rq_size(k) == 0) begin
            chk({name, " result present"}, 0, 1);
        end else begin
            r = (k == 0) ? rq0.pop_front() : rq1.pop_front();
            chk({name, " avg"}, r.avg, e_avg);
            chk({name, " avg_channel"}, r.ch, e_ch);
            chk({name, " next channel"}, r.nxt, e_nxt);
        end
    endtask

    task automatic expect_none(input int k, input int cycles, input string name);
        for (int i = 0; i < cycles; i++) tick();
        chk(name, rq_size(k), 0);
    endtask

    // ---------------- test sequence ----------------
    int seq [8];
    int off_cnt [2];

    initial begin
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
        set_in(0, 1'b0, 0, 0);
        set_in(1, 1'b0, 0, 0);
        tick();
        chk_on = 1'b1;
        tick(); tick();
        chk("reset channel", int'(ifc0.channel), 0);
        chk("reset avg_valid", int'(ifc0.avg_valid), 0);
        chk("reset avg", int'(ifc0.avg), 0);
        chk("reset avg_channel", int'(ifc0.avg_channel), 0);
        chk("reset dut1 channel", int'(ifc1.channel), 0);
        rst_n = 1'b1;
        tick();

        // 17 samples of 100 on ch0, first dropped.
        en0 = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) feed(0, 0, 100);
        wait_result(0, 100, 0, 1, "plain ch0");

        // Same again with foreign-channel strobes interleaved.
        en0 = 1'b0; tick(); tick();
        chk("idle channel", int'(ifc0.channel), 0);
        en0 = 1'b1; tick();
        for (int i = 0; i < 17; i++) begin
            feed(0, 3, 555);
            feed(0, 0, 100);
        end
        wait_result(0, 100, 0, 1, "interleaved ch0");

        // Rest of the scan, full-scale on ch1, wrapping 9 -> 0.
        seq = '{0, 1, 4, 5, 6, 7, 8, 9};
        for (int i = 1; i < 8; i++) begin
            for (int j = 0; j < 17; j++) feed(0, seq[i], (i == 1) ? 1023 : seq[i] * 10 + 3);
            wait_result(0, (i == 1) ? 1023 : seq[i] * 10 + 3, seq[i], seq[(i + 1) % 8], "scan");
        end

        // Enable drop after 8 accepted samples, then restart with discard.
        for (int i = 0; i < 9; i++) feed(0, 0, 200);
        en0 = 1'b0;
        expect_none(0, 4, "disable no emit");
        chk("disable channel", int'(ifc0.channel), 0);
        en0 = 1'b1; tick();
        feed(0, 0, 999);
        for (int i = 0; i < 16; i++) feed(0, 0, 7);
        wait_result(0, 7, 0, 1, "restart after disable");

        // Reset mid-accumulation.
        en0 = 1'b0; tick(); en0 = 1'b1; tick();
        for (int i = 0; i < 9; i++) feed(0, 0, 300);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("reset mid-accum channel", int'(ifc0.channel), 0);
        tick();
        feed(0, 0, 999);
        for (int i = 0; i < 16; i++) feed(0, 0, 50);
        wait_result(0, 50, 0, 1, "restart after reset");

        // Enable falls on the same edge as the 16th sample.
        en0 = 1'b0; tick(); en0 = 1'b1; tick();
        for (int i = 0; i < 16; i++) feed(0, 0, 40);
        set_in(0, 1'b1, 40, 0);
        en0 = 1'b0;
        tick();
        set_in(0, 1'b0, 0, 0);
        expect_none(0, 4, "enable vs final sample");
        chk("enable vs final channel", int'(ifc0.channel), 0);

        // AVG_LOG2=2, no discard, empty mask behaves as channel 0 only.
        en1 = 1'b1; tick();
        feed(1, 0, 1); feed(1, 5, 900); feed(1, 0, 1); feed(1, 0, 1); feed(1, 0, 2);
        wait_result(1, 1, 0, 0, "round 1112");
        feed(1, 0, 1); feed(1, 0, 2); feed(1, 0, 2); feed(1, 0, 2);
        wait_result(1, 2, 0, 0, "round 1222");
        feed(1, 0, 1); feed(1, 0, 1); feed(1, 0, 2); feed(1, 0, 2);
        wait_result(1, 2, 0, 0, "round 1122");

        // Randomized traffic on both instances.
        off_cnt[0] = 0; off_cnt[1] = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                logic e;
                int   v, sc;
                if (off_cnt[k] > 0) begin
                    off_cnt[k]--;
                    e = 1'b0;
                end else begin
                    e = 1'b1;
                    if ($urandom_range(0, 299) == 0) off_cnt[k] = $urandom_range(1, 6);
                end
                if (k == 0) en0 = e; else en1 = e;
                case ($urandom_range(0, 3))
                    0: v = 1023;
                    1: v = 0;
                    default: v = $urandom_range(0, 1023);
                endcase
                sc = ($urandom_range(0, 9) < 7) ? m_ch[k] : $urandom_range(0, 15);
                set_in(k, 1'($urandom_range(0, 1)), v, sc);
            end
            rst_n = ($urandom_range(0, 1999) != 0);
            tick();
        end
        rst_n = 1'b1;
        set_in(0, 1'b0, 0, 0);
        set_in(1, 1'b0, 0, 0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_scan_averager.md
ADC_SCAN_AVERAGER -- requirements
Module: adc_scan_averager

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 4: log2 of samples averaged per channel, legal range 0..6.
REQ-002 SHALL have parameter CH_MASK, default 16'h03F3: one bit per ADC channel to scan (Mojo channels 0,1,4-9).
REQ-003 SHALL have parameter DISCARD, default 1: number of samples (0 or 1) dropped after each channel switch for mux settling.
REQ-004 SHALL have port clk, input, 1 bit: the 50 MHz system clock, the only clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit: scan enable.
REQ-007 SHALL have port new_sample, input, 1 bit: one-cycle strobe from the AVR interface.
REQ-008 SHALL have port sample, input, 10 bits: ADC result, valid with new_sample.
REQ-009 SHALL have port sample_channel, input, 4 bits: channel of the sample, valid with new_sample.
REQ-010 SHALL have port channel, output, 4 bits: channel request to the AVR interface.
REQ-011 SHALL have port avg_valid, output, 1 bit: one-cycle result strobe.
REQ-012 SHALL have port avg, output, 10 bits: rounded mean.
REQ-013 SHALL have port avg_channel, output, 4 bits: channel of avg.

Function
REQ-014 SHALL run FSM states IDLE, SETTLE, ACCUM, EMIT.
REQ-015 IDLE: channel = lowest set bit of CH_MASK; when enable=1, go to SETTLE if DISCARD=1, otherwise go to ACCUM; accumulator and count are cleared.
REQ-016 A sample is "matching" only when new_sample=1 and sample_channel==channel; non-matching strobes SHALL be ignored in every state.
REQ-017 SETTLE: the first matching sample is dropped and the FSM goes to ACCUM with accumulator and count cleared.
REQ-018 ACCUM: each matching sample adds to a (10+AVG_LOG2)-bit accumulator and increments count.
REQ-019 ACCUM: on the matching sample that brings count to 2^AVG_LOG2, the FSM SHALL go to EMIT.
REQ-020 EMIT lasts exactly one cycle, asserting avg_valid=1, avg = (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2, and avg_channel = current channel.
REQ-021 When AVG_LOG2=0, no rounding term SHALL be added.
REQ-022 The rounded result cannot exceed 1023; no saturation logic is required.
REQ-023 Latency: the final sample is accepted at edge k, and avg_valid is high for the cycle following edge k+1.
REQ-024 avg and avg_channel SHALL hold their values until the next EMIT.
REQ-025 On leaving EMIT, channel SHALL advance to the next set bit of CH_MASK above the current one, wrapping from 15 to the lowest set bit; the FSM then enters SETTLE or ACCUM per DISCARD.
REQ-026 channel changes only on the EMIT exit edge and in IDLE.
REQ-027 A single-bit CH_MASK SHALL keep channel constant.
REQ-028 CH_MASK=0 SHALL be treated as 16'h0001.
REQ-029 new_sample arriving in the EMIT cycle SHALL be ignored.
REQ-030 enable=0 in any state SHALL force IDLE on the next edge and discard the partial accumulation without asserting avg_valid.
REQ-031 enable=0 coincident with the final sample: enable wins and no EMIT occurs.

Reset
REQ-032 rst_n=0 at an edge SHALL force state IDLE, channel = lowest mask bit, avg_valid=0, avg=0, avg_channel=0, accumulator=0, count=0.
REQ-033 Reset mid-accumulation SHALL discard all partial data, and the first result after reset SHALL use only post-reset samples.

Structure
REQ-034 A shared package adc_pkg SHALL hold ADC_W=10, CH_W=4, and the FSM state type.
REQ-035 One sub-module adc_next_channel SHALL provide combinational priority search of CH_MASK for the next set bit above a given channel, with wrap.
REQ-036 The block SHALL sit between avr_interface (channel/sample side) and the LED/tone consumers.

Verification
REQ-037 Defaults, enable=1, 17 matching ch0 samples of 100: first dropped, then one avg_valid with avg=100, avg_channel=0, then channel=1.
REQ-038 AVG_LOG2=2, samples 1,1,1,2: sum=5, avg=(5+2)>>2=1; samples 1,2,2,2: sum=7, avg=2 (rounding).
REQ-039 Sixteen samples of 1023: avg=1023 with no overflow; channel sequence over full scan: 0,1,4,5,6,7,8,9,0.
REQ-040 Interleaved strobes with sample_channel=3 while channel=0: ignored, and the result is identical to REQ-037.
REQ-041 Drop enable after 8 samples, re-enable: no avg_valid, restart at ch0 including discard; rst_n=0 mid-ACCUM has the same outcome.
REQ-042 enable=0 on the same cycle as the 16th sample: no avg_valid, state IDLE.
